// File: rtl/mod_cache_pkg.sv
// Shared definitions for the direct-mapped cache: controller state encoding
// and the tag-width derivation used by the top level.
package mod_cache_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_DWRITE = 3'd2,
    ST_DFILL  = 3'd3,
    ST_IFILL  = 3'd4
  } state_e;

  // Tag bits are whatever remains above the index and byte offset.
  function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

endpackage

// File: rtl/mod_cache_dm_array.sv
// Dual-port storage array for the cache. Port A is the only writer and also
// has its own read address. Port B is read-only. Reads are asynchronous and
// writes are synchronous.
module cache_array #(
  parameter int W  = 32,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we_a_i,
  input  logic [AW-1:0] waddr_a_i,
  input  logic [W-1:0]  wdata_a_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [W-1:0]  rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [W-1:0]  rdata_b_o
);

  logic [W-1:0] mem_q [2**AW];

  // Synchronous write through port A.
  always_ff @(posedge clk) begin
    if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mod_cache_dm.sv
// Direct-mapped, write-through / write-allocate unified cache with one
// instruction port and one data port in front of a req/ack memory.
// Handshake: mem_req stays high from the first cycle of a request state up to
// and including the cycle in which mem_ack is sampled high. mem_addr, mem_we
// and mem_wdata are captured when the request starts and stay stable while
// mem_req is high. mem_ack is ignored unless a request is outstanding.
// The controller state is held in state_q, which has type state_e.
module mod_cache_dm
  import mod_cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 11,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ie,
  input  logic              de,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [ADDR_W-1:0] daddr,
  input  logic              drw,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] iout,
  output logic [DATA_W-1:0] dout,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int TAG_W = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int TAG_LO = OFFSET_W + INDEX_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((1 << OFFSET_W) - 1));

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  cnt_q, cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [INDEX_W-1:0]  i_idx, d_idx, req_idx;
  logic [TAG_W-1:0]    i_tag, d_tag, req_tag;
  logic [TAG_W:0]      i_ent, d_ent, tag_wdata;
  logic [DATA_W-1:0]   i_data, d_data, line_wdata;
  logic [INDEX_W-1:0]  tag_waddr;
  logic                ihit, dhit, in_init, fill_done, tag_we;

  assign i_idx   = iaddr[TAG_LO-1:OFFSET_W];
  assign i_tag   = iaddr[ADDR_W-1:TAG_LO];
  assign d_idx   = daddr[TAG_LO-1:OFFSET_W];
  assign d_tag   = daddr[ADDR_W-1:TAG_LO];
  assign req_idx = mem_addr_q[TAG_LO-1:OFFSET_W];
  assign req_tag = mem_addr_q[ADDR_W-1:TAG_LO];

  // Tag entries carry the valid bit in the MSB.
  assign ihit = i_ent[TAG_W] && (i_ent[TAG_W-1:0] == i_tag);
  assign dhit = d_ent[TAG_W] && (d_ent[TAG_W-1:0] == d_tag);

  assign in_init   = (state_q == ST_INIT);
  assign fill_done = mem_req && mem_ack;

  // During the sweep the tag write port clears one entry per cycle; otherwise
  // it installs the tag of a completed request.
  assign tag_we     = in_init || fill_done;
  assign tag_waddr  = in_init ? cnt_q : req_idx;
  assign tag_wdata  = in_init ? '0 : {1'b1, req_tag};
  assign line_wdata = (state_q == ST_DWRITE) ? mem_wdata_q : mem_rdata;

  cache_array #(.W(DATA_W), .AW(INDEX_W)) u_data (
    .clk       (clk),
    .we_a_i    (fill_done),
    .waddr_a_i (req_idx),
    .wdata_a_i (line_wdata),
    .raddr_a_i (d_idx),
    .rdata_a_o (d_data),
    .raddr_b_i (i_idx),
    .rdata_b_o (i_data)
  );

  cache_array #(.W(TAG_W + 1), .AW(INDEX_W)) u_tag (
    .clk       (clk),
    .we_a_i    (tag_we),
    .waddr_a_i (tag_waddr),
    .wdata_a_i (tag_wdata),
    .raddr_a_i (d_idx),
    .rdata_a_o (d_ent),
    .raddr_b_i (i_idx),
    .rdata_b_o (i_ent)
  );

  assign iout      = in_init ? '0 : i_data;
  assign dout      = in_init ? '0 : d_data;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // State, sweep counter and request registers; reset abandons any request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next state, request capture, stall and memory request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_req     = 1'b0;
    cpu_stall   = (state_q != ST_IDLE) || flush || (de && drw) ||
                  (de && !dhit) || (ie && !ihit);
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + INDEX_W'(1);
        if (cnt_q == {INDEX_W{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // Flush beats stores, stores beat data misses, data beats instruction.
        if (flush) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (de && drw) begin
          state_d     = ST_DWRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = daddr & ALIGN_MASK;
          mem_wdata_d = din;
        end else if (de && !dhit) begin
          state_d     = ST_DFILL;
          mem_we_d    = 1'b0;
          mem_addr_d  = daddr & ALIGN_MASK;
          mem_wdata_d = '0;
        end else if (ie && !ihit) begin
          state_d     = ST_IFILL;
          mem_we_d    = 1'b0;
          mem_addr_d  = iaddr & ALIGN_MASK;
          mem_wdata_d = '0;
        end
      end
      ST_DWRITE, ST_DFILL, ST_IFILL: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_mod_cache_dm.sv
// Directed bench for mod_cache_dm with a 16-line geometry. A memory responder
// logs every request and acknowledges it one cycle after it first appears.
module tb_mod_cache_dm;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BOUND = 200;

  logic          clk;
  logic          rst;
  logic          flush, ie, de, drw;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] din, iout, dout;
  logic          cpu_stall, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack, resp_ack, late_ack;

  int checks = 0;
  int failures = 0;

  // Memory responder state and request log.
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  logic [AW-1:0] log_addr [$];
  logic [AW-1:0] exp_q [$];
  logic          last_we;
  logic [DW-1:0] last_wdata;
  logic          seen;
  logic          auto_ack;
  int            ack_cnt;

  assign mem_ack = resp_ack | late_ack;

  mod_cache_dm #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(4), .OFFSET_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .ie        (ie),
    .de        (de),
    .iaddr     (iaddr),
    .daddr     (daddr),
    .drw       (drw),
    .din       (din),
    .iout      (iout),
    .dout      (dout),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog in case a bounded wait is somehow bypassed.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Memory responder: log on first sight of a request, ack one cycle later.
  initial begin
    resp_ack = 1'b0;
    mem_rdata = '0;
    seen = 1'b0;
    ack_cnt = 0;
    last_we = 1'b0;
    last_wdata = '0;
    forever begin
      @(negedge clk);
      if (resp_ack) begin
        resp_ack = 1'b0;
      end else if (mem_req) begin
        if (!seen) begin
          log_addr.push_back(mem_addr);
          last_we = mem_we;
          last_wdata = mem_wdata;
          seen = 1'b1;
        end else if (auto_ack) begin
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : '0;
          resp_ack = 1'b1;
          ack_cnt++;
          seen = 1'b0;
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until the stall drops.
  task automatic wait_idle(input string tag);
    int n = 0;
    #1;
    while (cpu_stall === 1'b1 && n < BOUND) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_no_timeout"}, 32'(n < BOUND), 32'd1);
  endtask

  // Count stalled cycles of an INIT sweep; mem_req must never rise.
  task automatic count_init(input string tag);
    int n = 0;
    logic req_seen = 1'b0;
    #1;
    while (cpu_stall === 1'b1 && n < BOUND) begin
      if (mem_req !== 1'b0) req_seen = 1'b1;
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_len"}, n, 32'd16);
    check({tag, "_no_req"}, 32'(req_seen), 32'd0);
  endtask

  // Compare logged request addresses with the expected queue.
  task automatic drain_reqs(input string tag);
    check({tag, "_count"}, log_addr.size(), exp_q.size());
    while (exp_q.size() != 0 && log_addr.size() != 0)
      check({tag, "_addr"}, log_addr.pop_front(), exp_q.pop_front());
    exp_q.delete();
    log_addr.delete();
  endtask

  // Directed sequence.
  initial begin
    int acks0;
    int n;
    rst = 1'b1; flush = 1'b0; ie = 1'b0; de = 1'b0; drw = 1'b0;
    iaddr = '0; daddr = '0; din = '0; late_ack = 1'b0; auto_ack = 1'b1;
    mem_model[32'h40]  = 32'hDEADBEEF;
    mem_model[32'h204] = 32'h0BADF00D;
    mem_model[32'h100] = 32'h13572468;
    mem_model[32'h300] = 32'hCAFE0300;
    #2 rst = 1'b0;

    // Reset values.
    @(negedge clk); @(negedge clk); #1;
    check("rst_stall", 32'(cpu_stall), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_iout", iout, 32'h0);
    check("rst_dout", dout, 32'h0);

    // Initial sweep.
    @(negedge clk); rst = 1'b1;
    count_init("init");
    check("init_idle_stall", 32'(cpu_stall), 32'd0);

    // Read miss, then hit.
    @(negedge clk); de = 1'b1; drw = 1'b0; daddr = 32'h40;
    #1 check("rdmiss_stall", 32'(cpu_stall), 32'd1);
    wait_idle("rdmiss");
    exp_q.push_back(32'h40);
    drain_reqs("rdmiss");
    check("rdmiss_we", 32'(last_we), 32'd0);
    check("rdmiss_dout", dout, 32'hDEADBEEF);
    @(negedge clk); de = 1'b0;
    @(negedge clk); de = 1'b1;
    #1;
    check("rdhit_stall", 32'(cpu_stall), 32'd0);
    check("rdhit_req", 32'(mem_req), 32'd0);
    check("rdhit_dout", dout, 32'hDEADBEEF);

    // Simultaneous I and D misses: data side first.
    @(negedge clk); ie = 1'b1; iaddr = 32'h100; de = 1'b1; daddr = 32'h204;
    acks0 = ack_cnt;
    wait_idle("dual");
    check("dual_acks_before_release", ack_cnt - acks0, 32'd2);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h100);
    drain_reqs("dual");
    check("dual_dout", dout, 32'h0BADF00D);
    check("dual_iout", iout, 32'h13572468);

    // Write-through with allocate.
    @(negedge clk); ie = 1'b0; de = 1'b1; drw = 1'b1; daddr = 32'h80; din = 32'h12345678;
    acks0 = ack_cnt;
    n = 0;
    #1;
    while (ack_cnt == acks0 && n < BOUND) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wr_no_timeout", 32'(n < BOUND), 32'd1);
    de = 1'b0; drw = 1'b0;
    exp_q.push_back(32'h80);
    drain_reqs("wr");
    check("wr_we", 32'(last_we), 32'd1);
    check("wr_wdata", last_wdata, 32'h12345678);
    @(negedge clk); de = 1'b1; drw = 1'b0; daddr = 32'h80;
    #1;
    check("wr_hit_stall", 32'(cpu_stall), 32'd0);
    check("wr_hit_req", 32'(mem_req), 32'd0);
    check("wr_hit_dout", dout, 32'h12345678);

    // Refill 0x40, flush, then 0x40 must miss again.
    @(negedge clk); daddr = 32'h40;
    wait_idle("reload");
    exp_q.push_back(32'h40);
    drain_reqs("reload");
    @(negedge clk); de = 1'b0; flush = 1'b1;
    #1 check("flush_stall", 32'(cpu_stall), 32'd1);
    @(negedge clk); flush = 1'b0;
    count_init("flush_init");
    @(negedge clk); de = 1'b1; daddr = 32'h40;
    #1 check("postflush_miss", 32'(cpu_stall), 32'd1);
    wait_idle("postflush");
    exp_q.push_back(32'h40);
    drain_reqs("postflush");
    check("postflush_dout", dout, 32'hDEADBEEF);

    // Reset in the middle of a fill.
    @(negedge clk); auto_ack = 1'b0; daddr = 32'h300;
    @(negedge clk); #1;
    check("midfill_req", 32'(mem_req), 32'd1);
    check("midfill_addr", mem_addr, 32'h300);
    rst = 1'b0; de = 1'b0;
    #1;
    check("midfill_rst_req", 32'(mem_req), 32'd0);
    check("midfill_rst_addr", mem_addr, 32'h0);
    check("midfill_rst_stall", 32'(cpu_stall), 32'd1);
    check("midfill_rst_dout", dout, 32'h0);
    @(negedge clk); late_ack = 1'b1;
    @(negedge clk); late_ack = 1'b0;
    #1 check("late_ack_req", 32'(mem_req), 32'd0);
    @(negedge clk); rst = 1'b1;
    count_init("rst_init");
    exp_q.push_back(32'h300);
    drain_reqs("midfill");

    // Stray ack in IDLE does nothing.
    @(negedge clk); late_ack = 1'b1;
    #1 check("stray_ack_req", 32'(mem_req), 32'd0);
    @(negedge clk); late_ack = 1'b0;
    #1 check("stray_ack_stall", 32'(cpu_stall), 32'd0);

    // Fill completes normally after the abandoned one.
    @(negedge clk); auto_ack = 1'b1; de = 1'b1; daddr = 32'h300;
    wait_idle("refill");
    exp_q.push_back(32'h300);
    drain_reqs("refill");
    check("refill_dout", dout, 32'hCAFE0300);
    @(negedge clk); de = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
